// File: rtl/delay_line_sequencer.sv
// delay_line_sequencer
//   Arbitrates two word-wide requesters onto an external 1-bit, DEPTH-stage
//   shift-register delay chain. The granted word is shifted into the chain
//   LSB-first and flushed with zeros. The chain output is reassembled into a
//   response word that is tagged with the requester id.
//
// Parameters
//   WIDTH  bits per request word
//   DEPTH  stages in the attached chain (>= 1)
//   CNT_W  shift-counter width; 2**CNT_W must exceed WIDTH+DEPTH
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   ena                        1 = run, 0 = freeze FSM/counter/grants
//   req{0,1}_valid/_data       requester words
//   req{0,1}_ready             word accepted this cycle (combinational grant)
//   chain_shift, chain_din     advance chain / bit entering stage 0
//   chain_dout                 bit leaving stage DEPTH-1
//   rsp_valid/_data/_id/_ready response handshake
//   busy                       FSM not idle
//   txn_count [7:0]            only with DLS_TXN_CNT_EN defined: count of
//                              response handshakes, wraps at 255
module delay_line_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             chain_shift,
  output logic             chain_din,
  input  logic             chain_dout,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  input  logic             rsp_ready,
  output logic             busy
`ifdef DLS_TXN_CNT_EN
  ,
  output logic [7:0]       txn_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LP_LAST  = CNT_W'(WIDTH + DEPTH - 1);
  localparam logic [CNT_W-1:0] LP_WIDTH = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] LP_DEPTH = CNT_W'(DEPTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_word;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_id;
  logic             r_last;      // id granted most recently
  logic [WIDTH-1:0] w_word_sh;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_rsp_hs;

  // Bit n of the latched word, without a narrow index select.
  assign w_word_sh = r_word >> r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    chain_shift = 1'b0;
    chain_din   = 1'b0;
    w_rsp_hs    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ena) begin
          // req0 wins unless req1 is valid and req0 was served last.
          w_gnt0 = req0_valid & (r_last | ~req1_valid);
          w_gnt1 = req1_valid & ~w_gnt0;
          if (w_gnt0 | w_gnt1) begin
            w_state_nxt = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        if (ena) begin
          chain_shift = 1'b1;
          chain_din   = w_word_sh[0] & (r_cnt < LP_WIDTH);
          if (r_cnt == LP_LAST) begin
            w_state_nxt = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        // Handshake is honoured even while ena is low.
        w_rsp_hs = rsp_ready;
        if (rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_word     <= '0;
      r_id       <= 1'b0;
      r_last     <= 1'b1;
      r_rsp_data <= '0;
    end else if (w_gnt0) begin
      r_word <= req0_data;
      r_id   <= 1'b0;
      r_last <= 1'b0;
      r_cnt  <= '0;
    end else if (w_gnt1) begin
      r_word <= req1_data;
      r_id   <= 1'b1;
      r_last <= 1'b1;
      r_cnt  <= '0;
    end else if (chain_shift) begin
      r_cnt <= r_cnt + 1'b1;
      // Only bits inserted during this transaction reach the output; they
      // arrive LSB-first, so shift them in from the top.
      if (r_cnt >= LP_DEPTH) begin
        r_rsp_data <= (r_rsp_data >> 1) | (WIDTH'(chain_dout) << (WIDTH - 1));
      end
    end
  end

`ifdef DLS_TXN_CNT_EN
  logic [7:0] r_txn_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_txn_count <= '0;
    end else if (w_rsp_hs) begin
      r_txn_count <= r_txn_count + 8'd1;
    end
  end

  assign txn_count = r_txn_count;
`endif

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign rsp_valid  = (r_state == ST_RESP);
  assign rsp_data   = r_rsp_data;
  assign rsp_id     = r_id;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_delay_line_sequencer.sv
// Testbench for delay_line_sequencer: behavioural 8-stage chain, directed
// requests, response scoreboard checked by an independent monitor.
module tb_delay_line_sequencer;

  localparam int W = 8;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ena;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_data, req1_data;
  logic         req0_ready, req1_ready;
  logic         chain_shift, chain_din, chain_dout;
  logic         rsp_valid, rsp_id, rsp_ready, busy;
  logic [W-1:0] rsp_data;
`ifdef DLS_TXN_CNT_EN
  logic [7:0]   txn_count;
`endif

  logic [D-1:0] chain = '0;
  logic         preload = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int n_rsp    = 0;
  logic [8:0] sb[$];   // {id, data}

  always #5 clk = ~clk;

  delay_line_sequencer #(.WIDTH(W), .DEPTH(D), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .chain_shift(chain_shift), .chain_din(chain_din), .chain_dout(chain_dout),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_ready(rsp_ready), .busy(busy)
`ifdef DLS_TXN_CNT_EN
    , .txn_count(txn_count)
`endif
  );

  // External delay chain; not cleared by reset.
  always @(posedge clk) begin
    if (preload) chain <= '1;
    else if (chain_shift) chain <= {chain[D-2:0], chain_din};
  end
  assign chain_dout = chain[D-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      n_rsp++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_unexpected: got id %0d data 0x%0h expected none", rsp_id, rsp_data);
      end else begin
        check("rsp_word", 32'({rsp_id, rsp_data}), 32'(sb.pop_front()));
      end
    end
  end

  task automatic check_quiet(input string name);
    check({name, "_req0_ready"}, 32'(req0_ready), 0);
    check({name, "_req1_ready"}, 32'(req1_ready), 0);
    check({name, "_chain_shift"}, 32'(chain_shift), 0);
    check({name, "_chain_din"}, 32'(chain_din), 0);
    check({name, "_rsp_valid"}, 32'(rsp_valid), 0);
    check({name, "_rsp_data"}, 32'(rsp_data), 0);
    check({name, "_rsp_id"}, 32'(rsp_id), 0);
    check({name, "_busy"}, 32'(busy), 0);
`ifdef DLS_TXN_CNT_EN
    check({name, "_txn_count"}, 32'(txn_count), 0);
`endif
  endtask

  // Called at posedge+1; returns at posedge+1 just after the acceptance edge.
  task automatic grant(input int id, input logic [7:0] data, input bit push, output int waited);
    bit ok = 0;
    waited = 0;
    if (id == 0) begin req0_valid = 1; req0_data = data; end
    else         begin req1_valid = 1; req1_data = data; end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      check("ready_exclusive", 32'(req0_ready & req1_ready), 0);
      if ((id == 0) ? req0_ready : req1_ready) begin ok = 1; break; end
      waited++;
    end
    check("grant_seen", 32'(ok), 1);
    @(posedge clk);
    if (push && ok) sb.push_back({id[0], data});
    #1;
    if (id == 0) req0_valid = 0; else req1_valid = 0;
  endtask

  // Cycle k after the acceptance edge; ena held low for cycles p..p+l-1.
  task automatic trace(input int p, input int l, output int lat, output int nsh,
                       output logic [15:0] dv);
    lat = -1; nsh = 0; dv = '0;
    for (int k = 1; k <= 60; k++) begin
      ena = !(k >= p && k < p + l);
      @(negedge clk);
      if (!ena) check("pause_no_shift", 32'(chain_shift), 0);
      if (chain_shift) begin
        if (nsh < 16) dv[nsh] = chain_din;
        nsh++;
      end
      if (rsp_valid) begin lat = k; break; end
      @(posedge clk); #1;
    end
    ena = 1;
  endtask

  task automatic wait_drain();
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #2;
      if (sb.size() == 0 && !busy) begin ok = 1; break; end
    end
    check("drain", 32'(ok), 1);
  endtask

  task automatic do_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  initial begin
    int w, lat, nsh;
    logic [15:0] dv;
    rst_n = 0; ena = 1; rsp_ready = 1;
    req0_valid = 0; req1_valid = 0; req0_data = '0; req1_data = '0;

    // Reset state
    #1 check_quiet("rst_async");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    #1 check_quiet("rst_release");
    @(posedge clk); #1;

    // req0 0xA5: same-cycle ready, bit order, latency
    grant(0, 8'hA5, 1, w);
    check("req0_same_cycle", 32'(w), 0);
    trace(0, 0, lat, nsh, dv);
    check("a5_latency", 32'(lat), 17);
    check("a5_shift_cycles", 32'(nsh), 16);
    check("a5_din_seq", 32'(dv), 32'h00A5);
    @(posedge clk); #1;
    wait_drain();

    // Simultaneous 0x3C / 0xC3 from reset, then round-robin
    do_reset();
    req1_valid = 1; req1_data = 8'hC3;
    grant(0, 8'h3C, 1, w);
    check("pri_req0_from_reset", 32'(w), 0);
    grant(1, 8'hC3, 1, w);
    wait_drain();
`ifdef DLS_TXN_CNT_EN
    check("txn_count_2", 32'(txn_count), 2);
`endif
    req1_valid = 1; req1_data = 8'h22;
    grant(0, 8'h11, 1, w);
    check("rr_next_req0", 32'(w), 0);
    req1_valid = 0;
    wait_drain();

    // Response stall
    rsp_ready = 0;
    grant(0, 8'h96, 1, w);
    trace(0, 0, lat, nsh, dv);
    check("stall_latency", 32'(lat), 17);
    @(posedge clk); #1;
    req1_valid = 1; req1_data = 8'h69;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_rsp_valid", 32'(rsp_valid), 1);
      check("stall_rsp_data", 32'(rsp_data), 32'h96);
      check("stall_rsp_id", 32'(rsp_id), 0);
      check("stall_chain_shift", 32'(chain_shift), 0);
      check("stall_req0_ready", 32'(req0_ready), 0);
      check("stall_req1_ready", 32'(req1_ready), 0);
      @(posedge clk); #1;
    end
    rsp_ready = 1;
    grant(1, 8'h69, 1, w);
    wait_drain();

    // ena low: no grant in IDLE, then 3-cycle freeze at n=4
    ena = 0; req0_valid = 1; req0_data = 8'h5A;
    @(negedge clk);
    check("ena0_no_ready", 32'(req0_ready), 0);
    check("ena0_busy", 32'(busy), 0);
    @(posedge clk); #1;
    ena = 1;
    grant(0, 8'h5A, 1, w);
    trace(5, 3, lat, nsh, dv);
    check("pause_latency", 32'(lat), 20);
    check("pause_shift_cycles", 32'(nsh), 16);
    check("pause_din_seq", 32'(dv), 32'h005A);
    @(posedge clk); #1;
    wait_drain();

    // Stale chain ones, reset at n=6, then 0x00
    preload = 1;
    @(posedge clk); #1;
    preload = 0;
    grant(0, 8'hFF, 0, w);
    repeat (6) begin @(posedge clk); #1; end
    rst_n = 0;
    #1 check_quiet("abort");
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    grant(0, 8'h00, 1, w);
    trace(0, 0, lat, nsh, dv);
    check("zero_latency", 32'(lat), 17);
    @(posedge clk); #1;
    wait_drain();

    check("rsp_count", 32'(n_rsp), 8);
    check("sb_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
